// File: rtl/sto_pkg.sv
// sto_pkg: shared types and sizing helpers for the STO sequencer.
//   sto_state_e : sequencer state encoding
//   sto_w(n)    : bit width needed to index n items, never below 1
//   CH_W, SYM_W : index widths for the default build (2 channels, 4 symbols)
package sto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_PRIME   = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_SYM_END = 3'd4,
        ST_CALC    = 3'd5,
        ST_DONE    = 3'd6
    } sto_state_e;

    function automatic int unsigned sto_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned CH_W  = sto_w(2);
    localparam int unsigned SYM_W = sto_w(4);

endpackage

// File: rtl/sto_ch_pick.sv
// sto_ch_pick: finds the lowest set mask bit strictly above idx.
// With from_start=1 idx is treated as -1, which yields the lowest set bit.
// Ports:
//   mask       in  N_CH     channel mask
//   idx        in  CH_BITS  current channel index
//   from_start in  1        ignore idx and search from bit 0
//   nxt        out CH_BITS  selected channel (0 when none)
//   vld        out 1        a channel was found
module sto_ch_pick
    import sto_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CH_BITS = sto_w(N_CH)
) (
    input  logic [N_CH-1:0]    mask,
    input  logic [CH_BITS-1:0] idx,
    input  logic               from_start,
    output logic [CH_BITS-1:0] nxt,
    output logic               vld
);

    // Scan from the top down so the lowest qualifying bit is the last write.
    always_comb begin
        nxt = '0;
        vld = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(idx)))) begin
                nxt = CH_BITS'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sto_seq_ctrl.sv
// sto_seq_ctrl: sequencer for the sample-timing-offset estimation datapath.
// For every channel set in the latched mask it clears the accumulator and
// matched filter, primes the pipeline, accumulates N_SYM symbols of SYM_LEN
// samples and then hands the channel to the STO-calc stage.
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   go, abort              start request (IDLE only); terminate the run
//   ch_mask                channels to process, latched when go is accepted
//   smp_valid, calc_ready  front-end sample strobe; calc-stage ready
//   cnt_start              start pulse for the downstream sample counter
//   accu_rst, accu_ld      accumulator clear / load
//   mf_rst, mf_ld          matched-filter clear / load
//   ch_sel, sym_idx        active channel, current symbol
//   sto_calc_en            STO-calc enable
//   busy, done, err        run status; done/err are one-cycle pulses
//   dbg_state              current sequencer state
//
// calc handshake: sto_calc_en stays high for the whole CALC state. A cycle in
// which sto_calc_en and calc_ready are both high hands the channel over; the
// sequencer leaves CALC on the next edge. calc_ready is ignored otherwise.
module sto_seq_ctrl
    import sto_pkg::*;
#(
    parameter int unsigned SYM_LEN   = 80,
    parameter int unsigned N_SYM     = 4,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned PRIME_CYC = 2,
    parameter int unsigned CALC_TO   = 255,
    localparam int unsigned CH_BITS  = sto_w(N_CH),
    localparam int unsigned SYM_BITS = sto_w(N_SYM)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                abort,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic                smp_valid,
    input  logic                calc_ready,
    output logic                cnt_start,
    output logic                accu_rst,
    output logic                accu_ld,
    output logic                mf_rst,
    output logic                mf_ld,
    output logic [CH_BITS-1:0]  ch_sel,
    output logic [SYM_BITS-1:0] sym_idx,
    output logic                sto_calc_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output sto_state_e          dbg_state
);

    localparam int unsigned SMP_BITS = sto_w(SYM_LEN);
    localparam int unsigned PR_BITS  = sto_w(PRIME_CYC);
    localparam int unsigned TO_BITS  = sto_w(CALC_TO);

    localparam logic [SMP_BITS-1:0] SMP_LAST = SMP_BITS'(SYM_LEN - 1);
    localparam logic [SYM_BITS-1:0] SYM_LAST = SYM_BITS'(N_SYM - 1);
    localparam logic [PR_BITS-1:0]  PR_LAST  = PR_BITS'(PRIME_CYC - 1);
    localparam logic [TO_BITS-1:0]  TO_LAST  = TO_BITS'(CALC_TO - 1);

    sto_state_e          state_q, state_d;
    logic [N_CH-1:0]     mask_q;
    logic [CH_BITS-1:0]  ch_sel_q;
    logic [SMP_BITS-1:0] smp_cnt;
    logic [SYM_BITS-1:0] sym_cnt;
    logic [PR_BITS-1:0]  pr_cnt;
    logic [TO_BITS-1:0]  to_cnt;
    logic                err_q, err_set;

    logic                in_idle;
    logic [N_CH-1:0]     pick_mask;
    logic [CH_BITS-1:0]  pick_nxt;
    logic                pick_vld;

    // One picker serves both the initial lowest-bit search (IDLE, live mask)
    // and the next-channel search after a calc handover (latched mask).
    assign in_idle   = (state_q == ST_IDLE);
    assign pick_mask = in_idle ? ch_mask : mask_q;

    sto_ch_pick #(
        .N_CH    (N_CH),
        .CH_BITS (CH_BITS)
    ) u_pick (
        .mask       (pick_mask),
        .idx        (ch_sel_q),
        .from_start (in_idle),
        .nxt        (pick_nxt),
        .vld        (pick_vld)
    );

    // Next-state logic; err_set marks transitions that end in an error pulse.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (pick_vld) state_d = ST_CLR;
                    else          err_set = 1'b1;
                end
            end
            ST_CLR:   state_d = ST_PRIME;
            ST_PRIME: if (pr_cnt == PR_LAST) state_d = ST_ACCUM;
            ST_ACCUM: if (smp_valid && (smp_cnt == SMP_LAST)) state_d = ST_SYM_END;
            ST_SYM_END: state_d = (sym_cnt == SYM_LAST) ? ST_CALC : ST_ACCUM;
            ST_CALC: begin
                if (calc_ready) begin
                    state_d = pick_vld ? ST_CLR : ST_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // abort overrides every other transition while a run is active
        if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d = ST_DONE;
            err_set = 1'b1;
        end
    end

    // Moore output decode; accu_ld is the only output qualified by an input.
    always_comb begin
        cnt_start   = 1'b0;
        accu_rst    = 1'b0;
        accu_ld     = 1'b0;
        mf_rst      = 1'b0;
        mf_ld       = 1'b0;
        sto_calc_en = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            ST_IDLE:    busy = 1'b0;
            ST_CLR: begin
                accu_rst = 1'b1;
                mf_rst   = 1'b1;
            end
            ST_PRIME: begin
                accu_rst  = 1'b1;
                cnt_start = (pr_cnt == '0);
            end
            ST_ACCUM:   accu_ld = smp_valid;
            ST_SYM_END: begin
                mf_ld    = 1'b1;
                accu_rst = 1'b1;
            end
            ST_CALC:    sto_calc_en = 1'b1;
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default:    busy = 1'b0;
        endcase
    end

    assign ch_sel    = ch_sel_q;
    assign sym_idx   = sym_cnt;
    assign err       = err_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            mask_q   <= '0;
            ch_sel_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_set;
            if (in_idle && (state_d == ST_CLR)) mask_q <= ch_mask;
            // every entry into CLR starts a channel: the picker already
            // holds the right index for either entry path
            if ((state_d == ST_CLR) && pick_vld) ch_sel_q <= pick_nxt;
        end
    end

    // Counters restart on every CLR entry and are parked at zero outside a run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp_cnt <= '0;
            sym_cnt <= '0;
            pr_cnt  <= '0;
            to_cnt  <= '0;
        end else if ((state_d == ST_CLR) || (state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            smp_cnt <= '0;
            sym_cnt <= '0;
            pr_cnt  <= '0;
            to_cnt  <= '0;
        end else begin
            case (state_q)
                ST_PRIME: pr_cnt <= pr_cnt + 1'b1;
                ST_ACCUM: begin
                    if (smp_valid) smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
                end
                ST_SYM_END: begin
                    smp_cnt <= '0;
                    if (sym_cnt != SYM_LAST) sym_cnt <= sym_cnt + 1'b1;
                end
                ST_CALC:  to_cnt <= to_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sto_seq_ctrl.sv
module tb_sto_seq_ctrl;
  import sto_pkg::*;

  localparam int SYM_LEN   = 4;
  localparam int N_SYM     = 2;
  localparam int N_CH      = 2;
  localparam int PRIME_CYC = 2;
  localparam int CALC_TO   = 8;
  localparam int BUDGET    = 200;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       go, abort, smp_valid, calc_ready;
  logic [1:0] ch_mask;
  logic       cnt_start, accu_rst, accu_ld, mf_rst, mf_ld;
  logic [0:0] ch_sel, sym_idx;
  logic       sto_calc_en, busy, done, err;
  sto_state_e dbg_state;

  always #5 clk = ~clk;

  sto_seq_ctrl #(
    .SYM_LEN   (SYM_LEN),
    .N_SYM     (N_SYM),
    .N_CH      (N_CH),
    .PRIME_CYC (PRIME_CYC),
    .CALC_TO   (CALC_TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .abort       (abort),
    .ch_mask     (ch_mask),
    .smp_valid   (smp_valid),
    .calc_ready  (calc_ready),
    .cnt_start   (cnt_start),
    .accu_rst    (accu_rst),
    .accu_ld     (accu_ld),
    .mf_rst      (mf_rst),
    .mf_ld       (mf_ld),
    .ch_sel      (ch_sel),
    .sym_idx     (sym_idx),
    .sto_calc_en (sto_calc_en),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- vector table ----------------
  // Cycle numbers are relative to the accepted go (go edge = 0, CLR = 1).
  typedef struct {
    logic [1:0] mask;
    bit         gap;      // smp_valid only on even cycles
    int         rdy_dly;  // calc_ready after this many CALC cycles, -1 never
    int         abort_at;
    int         go_at;    // stray go during the run
    int         e_accu, e_mfld, e_mfrst, e_start, e_calc, e_done, e_err, e_ch;
  } vec_t;

  vec_t vecs[8];

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];   // {err, done cycle}

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int nth_set(input logic [1:0] m, input int n);
    int k = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        if (k == n) return i;
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int outs_word();
    return int'({cnt_start, accu_rst, accu_ld, mf_rst, mf_ld, ch_sel, sym_idx,
                 sto_calc_en, busy, done, err});
  endfunction

  // ---------------- driver / monitor for one table row ----------------
  task automatic run_case(input int id, input vec_t v);
    int accu_cnt = 0, mfld_cnt = 0, mfrst_cnt = 0, start_cnt = 0;
    int done_cnt = 0, err_cnt = 0, en_run = 0, accu_since = 0;
    int calc_rel = -1, done_rel = -1, busy_bad = 0;
    logic [8:0] exp_item, act_item;
    string tag;
    tag = $sformatf("row%0d", id);
    exp_q.push_back({v.e_err[0], 8'(v.e_done)});

    @(posedge clk); #1;
    ch_mask = v.mask; go = 1'b1; smp_valid = 1'b0; calc_ready = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    ch_mask = ~v.mask;   // must be ignored while busy

    for (int rel = 1; rel < BUDGET && !(done_rel >= 0 && rel > done_rel + 1); rel++) begin
      if (rel > 1) begin
        @(posedge clk); #1;
      end
      smp_valid  = v.gap ? (rel % 2 == 0) : 1'b1;
      calc_ready = (v.rdy_dly > 0) && (en_run == v.rdy_dly);
      abort      = (rel == v.abort_at);
      go         = (rel == v.go_at);
      @(negedge clk);
      if (accu_ld) begin
        accu_cnt++;
        accu_since++;
      end
      if (mf_ld) begin
        check({tag, " sym_idx@mf_ld"}, int'(sym_idx), mfld_cnt % N_SYM);
        check({tag, " ch_sel@mf_ld"}, int'(ch_sel), nth_set(v.mask, mfld_cnt / N_SYM));
        check({tag, " accu_ld per symbol"}, accu_since, SYM_LEN);
        accu_since = 0;
        mfld_cnt++;
      end
      if (mf_rst) begin
        check({tag, " ch_sel@clr"}, int'(ch_sel), nth_set(v.mask, mfrst_cnt));
        mfrst_cnt++;
      end
      if (cnt_start) start_cnt++;
      if (err) err_cnt++;
      if (sto_calc_en) begin
        en_run++;
        if (calc_rel < 0) calc_rel = rel;
      end else begin
        en_run = 0;
      end
      if (done) begin
        done_cnt++;
        check({tag, " busy@done"}, int'(busy), 0);
        if (done_rel < 0) done_rel = rel;
        act_item = {err, 8'(rel)};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s unexpected done: got cycle %0d, expected none", tag, rel);
        end else begin
          exp_item = exp_q.pop_front();
          check({tag, " {err,done cycle}"}, int'(act_item), int'(exp_item));
        end
      end else if (done_rel < 0 && !busy) begin
        busy_bad++;
      end
      if (done_rel >= 0 && rel == done_rel + 1) begin
        check({tag, " state after done"}, int'(dbg_state), int'(ST_IDLE));
        check({tag, " busy after done"}, int'(busy), 0);
      end
    end

    go = 1'b0; abort = 1'b0; calc_ready = 1'b0; smp_valid = 1'b0;
    if (done_rel < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: got no done in %0d cycles, expected done at %0d", tag, BUDGET, v.e_done);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check({tag, " accu_ld count"}, accu_cnt, v.e_accu);
    check({tag, " mf_ld count"}, mfld_cnt, v.e_mfld);
    check({tag, " mf_rst count"}, mfrst_cnt, v.e_mfrst);
    check({tag, " cnt_start count"}, start_cnt, v.e_start);
    check({tag, " calc entry cycle"}, calc_rel, v.e_calc);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " err count"}, err_cnt, v.e_err);
    check({tag, " busy gaps"}, busy_bad, 0);
    check({tag, " final ch_sel"}, int'(ch_sel), v.e_ch);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int done_seen;
    //             mask gap dly abrt go  accu mfld rst st calc done err ch
    vecs[0] = '{2'b01, 1'b0,  3, -1, -1,  8, 2, 1, 1, 14, 18, 0, 0};
    vecs[1] = '{2'b01, 1'b1,  3, -1, -1,  8, 2, 1, 1, 20, 24, 0, 0};
    vecs[2] = '{2'b11, 1'b0,  3, -1, -1, 16, 4, 2, 2, 14, 35, 0, 1};
    vecs[3] = '{2'b10, 1'b0,  1, -1, -1,  8, 2, 1, 1, 14, 16, 0, 1};
    vecs[4] = '{2'b01, 1'b0, -1, -1, -1,  8, 2, 1, 1, 14, 22, 1, 0};
    vecs[5] = '{2'b01, 1'b0,  7, -1, -1,  8, 2, 1, 1, 14, 22, 0, 0};
    vecs[6] = '{2'b01, 1'b0,  3, 10,  6,  6, 1, 1, 1, -1, 11, 1, 0};
    vecs[7] = '{2'b11, 1'b1,  1, -1, -1, 16, 4, 2, 2, 20, 44, 0, 1};

    reset = 1'b1; go = 1'b0; abort = 1'b0; smp_valid = 1'b0; calc_ready = 1'b0; ch_mask = 2'b00;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", outs_word(), 0);
    check("reset state", int'(dbg_state), int'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);
    check("idle outputs", outs_word(), 0);

    for (int i = 0; i < 8; i++) run_case(i, vecs[i]);

    // empty mask: err pulses one cycle after go, nothing else moves
    @(posedge clk); #1;
    go = 1'b1; ch_mask = 2'b00;
    @(negedge clk);
    check("empty go cycle err", int'(err), 0);
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    check("empty err pulse", int'(err), 1);
    check("empty done", int'(done), 0);
    check("empty busy", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("empty err clears", int'(err), 0);
    check("empty state", int'(dbg_state), int'(ST_IDLE));

    // reset in the middle of PRIME
    @(posedge clk); #1;
    go = 1'b1; ch_mask = 2'b10;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    check("mid clr mf_rst", int'(mf_rst), 1);
    check("mid clr ch_sel", int'(ch_sel), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid prime cnt_start", int'(cnt_start), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid prime2 cnt_start", int'(cnt_start), 0);
    check("mid prime2 accu_rst", int'(accu_rst), 1);
    #2 reset = 1'b0;
    #1;
    check("async reset outputs", outs_word(), 0);
    check("async reset state", int'(dbg_state), int'(ST_IDLE));
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no done after reset", done_seen, 0);
    check("post reset outputs", outs_word(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
